unified_memory_arbiter: RTL and testbench

UNIFIED_MEMORY_ARBITER -- requirements
Module: unified_memory_arbiter

---
 rtl/unified_memory_arbiter.sv | 118 +++++++++++
 tb/tb_unified_memory_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_memory_arbiter.sv
// Two-port read arbiter with write-through priority in front of a single-port RAM.
// Define ARB_ROUND_ROBIN_EN to alternate between simultaneous readers instead of fixed port-1 priority.
module unified_memory_arbiter #(
    parameter int ADDR_W = 15,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en     [0:1],
    input  logic [ADDR_W-1:0] rd_addr   [0:1],
    input  logic [1:0]        wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [15:0]       wr_data,
    output logic              rd_done   [0:1],
    output logic [15:0]       rd_data   [0:1],
    output logic              ram_en,
    output logic [1:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,
    output logic              busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int CNT_W = 3;

    logic [1:0]       state;
    logic             sel;
    logic [CNT_W-1:0] cnt;
    logic             elig0;
    logic             elig1;
    logic             grant;
    logic             issue;

    // A port that is completing this cycle must not be granted again in the same cycle.
    assign elig0 = rd_en[0] & ~rd_done[0];
    assign elig1 = rd_en[1] & ~rd_done[1];

`ifdef ARB_ROUND_ROBIN_EN
    logic last_sel;

    assign grant = (elig0 && elig1) ? ~last_sel : elig1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_sel <= 1'b0;
        end else if (issue) begin
            last_sel <= grant;
        end
    end
`else
    assign grant = elig1;
`endif

    assign issue = (state == IDLE) && (wr_en == 2'b00) && (elig0 || elig1);

    // NOTE: every output gets a default first so no path through this block infers a latch.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 2'b00;
        ram_addr  = '0;
        ram_wdata = '0;
        if (wr_en != 2'b00) begin
            ram_en    = 1'b1;
            ram_we    = wr_en;
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
        end else if (issue) begin
            ram_en   = 1'b1;
            ram_addr = rd_addr[grant];
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sel        <= 1'b0;
            cnt        <= '0;
            rd_data[0] <= '0;
            rd_data[1] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state <= WAIT;
                        sel   <= grant;
                        cnt   <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    // The counter reaching RD_LAT marks the cycle in which ram_rdata is valid.
                    if (cnt == CNT_W'(RD_LAT)) begin
                        rd_data[sel] <= ram_rdata;
                        state        <= DONE;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign rd_done[0] = (state == DONE) && !sel;
    assign rd_done[1] = (state == DONE) &&  sel;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Self-checking bench for unified_memory_arbiter: directed cases plus randomized reads/writes
// against a shadow memory model; a second instance runs with RD_LAT=4.
module tb_unified_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset;

    logic        rd_en     [0:1];
    logic [14:0] rd_addr   [0:1];
    logic [1:0]  wr_en;
    logic [14:0] wr_addr;
    logic [15:0] wr_data;
    logic        rd_done   [0:1];
    logic [15:0] rd_data   [0:1];
    logic        ram_en;
    logic [1:0]  ram_we;
    logic [14:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        busy;

    logic        rd_en4    [0:1];
    logic [14:0] rd_addr4  [0:1];
    logic [1:0]  wr_en4;
    logic [14:0] wr_addr4;
    logic [15:0] wr_data4;
    logic        rd_done4  [0:1];
    logic [15:0] rd_data4  [0:1];
    logic        ram_en4;
    logic [1:0]  ram_we4;
    logic [14:0] ram_addr4;
    logic [15:0] ram_wdata4;
    logic [15:0] ram_rdata4;
    logic        busy4;

    int errors = 0;
    int checks = 0;

    logic [15:0] ref_mem     [0:63];
    logic [15:0] exp_rd_data [0:1];

    always #5 clk = ~clk;

    unified_memory_arbiter #(.ADDR_W(15), .RD_LAT(1)) u_dut (
        .clk(clk), .reset(reset),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_done(rd_done), .rd_data(rd_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    unified_memory_arbiter #(.ADDR_W(15), .RD_LAT(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .rd_en(rd_en4), .rd_addr(rd_addr4),
        .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
        .rd_done(rd_done4), .rd_data(rd_data4),
        .ram_en(ram_en4), .ram_we(ram_we4), .ram_addr(ram_addr4), .ram_wdata(ram_wdata4),
        .ram_rdata(ram_rdata4), .busy(busy4)
    );

    // Synchronous byte-lane RAM, one-cycle read latency.
    logic [15:0] mem  [0:63];
    logic [15:0] pipe1;
    always @(posedge clk) begin
        if (ram_en && ram_we[0]) mem[ram_addr[5:0]][7:0]  <= ram_wdata[7:0];
        if (ram_en && ram_we[1]) mem[ram_addr[5:0]][15:8] <= ram_wdata[15:8];
        if (ram_en && ram_we == 2'b00) pipe1 <= mem[ram_addr[5:0]];
    end
    assign ram_rdata = pipe1;

    // Same RAM with a four-stage read pipeline.
    logic [15:0] mem4  [0:63];
    logic [15:0] pipe4 [0:3];
    always @(posedge clk) begin
        if (ram_en4 && ram_we4[0]) mem4[ram_addr4[5:0]][7:0]  <= ram_wdata4[7:0];
        if (ram_en4 && ram_we4[1]) mem4[ram_addr4[5:0]][15:8] <= ram_wdata4[15:8];
        pipe4[0] <= (ram_en4 && ram_we4 == 2'b00) ? mem4[ram_addr4[5:0]] : 16'h0000;
        pipe4[1] <= pipe4[0];
        pipe4[2] <= pipe4[1];
        pipe4[3] <= pipe4[2];
    end
    assign ram_rdata4 = pipe4[3];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_write(input logic [14:0] a, input logic [1:0] be, input logic [15:0] d);
        if (be[0]) ref_mem[a[5:0]][7:0]  = d[7:0];
        if (be[1]) ref_mem[a[5:0]][15:8] = d[15:8];
    endtask

    // One IDLE-cycle write; checks the RAM strobe passes straight through.
    task automatic do_write(input logic [14:0] a, input logic [1:0] be, input logic [15:0] d);
        wr_en = be; wr_addr = a; wr_data = d;
        #1;
        check("wr_ram_en", ram_en, 1);
        check("wr_ram_we", ram_we, be);
        check("wr_ram_addr", ram_addr, a);
        check("wr_ram_wdata", ram_wdata, d);
        ref_write(a, be, d);
        next_cycle();
        wr_en = 2'b00;
    endtask

    // Read on port p starting this cycle; optional write in the first wait cycle.
    task automatic do_read(input int p, input logic [14:0] a, input bit wr_in_wait,
                           input logic [14:0] wa, input logic [1:0] wbe, input logic [15:0] wd,
                           input string tag);
        logic [15:0] exp_d;
        int          lat;
        bit          got;
        exp_d = ref_mem[a[5:0]];
        wr_en = 2'b00;
        rd_en[p] = 1'b1; rd_addr[p] = a;
        #1;
        check({tag, "_issue_en"}, ram_en, 1);
        check({tag, "_issue_we"}, ram_we, 0);
        check({tag, "_issue_addr"}, ram_addr, a);
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            next_cycle();
            if (wr_in_wait && k == 1) begin
                wr_en = wbe; wr_addr = wa; wr_data = wd;
            end else begin
                wr_en = 2'b00;
            end
            #1;
            if (wr_in_wait && k == 1) begin
                check({tag, "_wait_wr_we"}, ram_we, wbe);
                check({tag, "_wait_wr_addr"}, ram_addr, wa);
                check({tag, "_wait_wr_data"}, ram_wdata, wd);
                ref_write(wa, wbe, wd);
            end else begin
                check({tag, "_busy_ram_idle"}, ram_en, 0);
            end
            check({tag, "_other_done"}, rd_done[1-p], 0);
            if (rd_done[p]) begin
                got = 1'b1;
                lat = k;
            end
        end
        check({tag, "_done_seen"}, got, 1);
        check({tag, "_latency"}, lat, 2);
        check({tag, "_data"}, rd_data[p], exp_d);
        check({tag, "_other_data"}, rd_data[1-p], exp_rd_data[1-p]);
        exp_rd_data[p] = exp_d;
        rd_en[p] = 1'b0;
        wr_en = 2'b00;
        next_cycle();
    endtask

    initial begin
        int          exp_order [0:3];
        int          served;
        int          port;
        int          done_k;
        int          busy_cnt;
        logic [14:0] a;
        logic [14:0] wa;
        logic [1:0]  be;
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{1, 0, 1, 0};
`else
        exp_order = '{1, 1, 1, 1};
`endif
        reset = 1'b0;
        rd_en[0] = 1'b0; rd_en[1] = 1'b0; rd_addr[0] = 15'h0; rd_addr[1] = 15'h0;
        wr_en = 2'b00; wr_addr = 15'h0; wr_data = 16'h0;
        rd_en4[0] = 1'b0; rd_en4[1] = 1'b0; rd_addr4[0] = 15'h0; rd_addr4[1] = 15'h0;
        wr_en4 = 2'b00; wr_addr4 = 15'h0; wr_data4 = 16'h0;
        exp_rd_data[0] = 16'h0; exp_rd_data[1] = 16'h0;

        // Reset state, with request inputs active to prove reset dominates.
        rd_en[0] = 1'b1; rd_addr[0] = 15'h0033;
        repeat (2) next_cycle();
        check("rst_busy", busy, 0);
        check("rst_done0", rd_done[0], 0);
        check("rst_done1", rd_done[1], 0);
        check("rst_data0", rd_data[0], 0);
        check("rst_data1", rd_data[1], 0);
        rd_en[0] = 1'b0;
        reset = 1'b1;
        next_cycle();

        // Idle bus: stray address/data inputs must not leak onto the RAM port.
        rd_addr[0] = 15'h1234; rd_addr[1] = 15'h0777; wr_addr = 15'h0555; wr_data = 16'hBEEF;
        #1;
        check("idle_ram_en", ram_en, 0);
        check("idle_ram_we", ram_we, 0);
        check("idle_ram_addr", ram_addr, 0);
        check("idle_ram_wdata", ram_wdata, 0);
        check("idle_busy", busy, 0);
        next_cycle();

        // Preload every word with random data through the write port.
        for (int i = 0; i < 64; i++) begin
            do_write(15'(i), 2'b11, 16'($urandom));
        end

        // Single fetch.
        do_write(15'h0010, 2'b11, 16'hA55A);
        do_read(0, 15'h0010, 1'b0, 15'h0, 2'b00, 16'h0, "fetch");
        check("fetch_const", rd_data[0], 16'hA55A);

        // Low-byte write over existing word, then data-port read.
        do_write(15'h0004, 2'b11, 16'hABCD);
        do_write(15'h0004, 2'b01, 16'h12FF);
        do_read(1, 15'h0004, 1'b0, 15'h0, 2'b00, 16'h0, "bytewr");
        check("bytewr_const", rd_data[1], 16'hABFF);

        // Write during WAIT lands immediately and leaves the read unchanged.
        do_read(1, 15'h0010, 1'b1, 15'h0020, 2'b11, 16'h6789, "waitwr");
        do_read(0, 15'h0020, 1'b0, 15'h0, 2'b00, 16'h0, "waitwr_rb");
        check("waitwr_rb_const", rd_data[0], 16'h6789);

        // A write in IDLE takes the RAM and pushes the pending read back one cycle.
        rd_en[0] = 1'b1; rd_addr[0] = 15'h0021;
        wr_en = 2'b10; wr_addr = 15'h0021; wr_data = 16'h3C00;
        #1;
        check("wrprio_we", ram_we, 2'b10);
        check("wrprio_addr", ram_addr, 15'h0021);
        ref_write(15'h0021, 2'b10, 16'h3C00);
        next_cycle();
        check("wrprio_no_issue", busy, 0);
        do_read(0, 15'h0021, 1'b0, 15'h0, 2'b00, 16'h0, "wrprio");

        // Contention: both ports held for four completions.
        rd_en[0] = 1'b1; rd_addr[0] = 15'h0011;
        rd_en[1] = 1'b1; rd_addr[1] = 15'h0022;
        served = 0;
        for (int k = 0; k < 60 && served < 4; k++) begin
            #1;
            if (rd_done[0] || rd_done[1]) begin
                port = rd_done[1] ? 1 : 0;
                check("cont_port", port, exp_order[served]);
                check("cont_data", rd_data[port], ref_mem[port == 1 ? 6'h22 : 6'h11]);
                exp_rd_data[port] = ref_mem[port == 1 ? 6'h22 : 6'h11];
                served++;
                if (served == 4) begin
                    rd_en[0] = 1'b0; rd_en[1] = 1'b0;
                end
            end
            next_cycle();
        end
        check("cont_count", served, 4);
        check("cont_data0_kept", rd_data[0], exp_rd_data[0]);
        next_cycle();

        // Reset in WAIT aborts the read; the held request then completes normally.
        rd_en[0] = 1'b1; rd_addr[0] = 15'h0010;
        #1;
        check("rstmid_issue", ram_en, 1);
        next_cycle();
        check("rstmid_wait_busy", busy, 1);
        reset = 1'b0;
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_done0", rd_done[0], 0);
        check("rstmid_data0", rd_data[0], 0);
        next_cycle();
        check("rstmid_done0_hold", rd_done[0], 0);
        check("rstmid_busy_hold", busy, 0);
        reset = 1'b1;
        exp_rd_data[0] = 16'h0; exp_rd_data[1] = 16'h0;
        do_read(0, 15'h0010, 1'b0, 15'h0, 2'b00, 16'h0, "rstmid_after");

        // Randomized reads with optional preceding and in-flight writes.
        for (int i = 0; i < 30; i++) begin
            a = 15'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                be = 2'($urandom_range(1, 3));
                wa = ($urandom_range(0, 1) == 1) ? a : 15'($urandom_range(0, 63));
                do_write(wa, be, 16'($urandom));
            end
            wa = 15'((a + 15'($urandom_range(1, 63))) % 64);
            be = 2'($urandom_range(1, 3));
            do_read(int'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), wa, be,
                    16'($urandom), "rand");
        end

        // RD_LAT=4 instance: latency and busy length.
        wr_en4 = 2'b11; wr_addr4 = 15'h0007; wr_data4 = 16'h5A3C;
        next_cycle();
        wr_en4 = 2'b00;
        rd_en4[0] = 1'b1; rd_addr4[0] = 15'h0007;
        #1;
        check("lat4_issue_en", ram_en4, 1);
        check("lat4_issue_addr", ram_addr4, 15'h0007);
        done_k = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            next_cycle();
            #1;
            if (busy4) busy_cnt++;
            if (rd_done4[1]) check("lat4_done1", rd_done4[1], 0);
            if (rd_done4[0] && done_k == 0) begin
                done_k = k;
                check("lat4_data", rd_data4[0], 16'h5A3C);
                rd_en4[0] = 1'b0;
            end
        end
        check("lat4_done_cycle", done_k, 5);
        check("lat4_busy_cycles", busy_cnt, 5);
        check("lat4_data1_kept", rd_data4[1], 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
